// File: rtl/adder_pkg.sv
// Shared definitions for the chunked adder: FSM state encoding, default
// operand/chunk widths and a helper that sizes the slice counter.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  // Counter width for n slices; never narrower than one bit so N=1 still works.
  function automatic int cnt_width(input int n);
    cnt_width = (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/full_adder_chunk.sv
// Combinational CHUNK-bit ripple adder. Besides the carry out of the top
// bit it exposes the carry into the top bit, which the parent needs to
// derive signed overflow on the most significant slice.
module full_adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  // Ripple the carry through every bit of the slice.
  always_comb begin : ripple
    logic [CHUNK:0] c;
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[CHUNK];
    cmsb = c[CHUNK-1];
  end

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: a WIDTH-bit operation is performed CHUNK
// bits per clock, LSB slice first, with the carry held in a register between
// slices. Valid/ready handshakes on both sides; one operation at a time.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             ovf_r;

  logic [CHUNK-1:0] slice_a_s;
  logic [CHUNK-1:0] slice_b_s;
  logic [CHUNK-1:0] slice_sum_s;
  logic             slice_cout_s;
  logic             slice_cmsb_s;
  logic             last_slice_s;

  assign last_slice_s = (cnt_r == LAST_CNT);

  // Pick the operand slice addressed by the counter (constant-index mux).
  always_comb begin
    slice_a_s = '0;
    slice_b_s = '0;
    for (int k = 0; k < N; k++) begin
      slice_a_s = (cnt_r == CW'(k)) ? a_r[k*CHUNK +: CHUNK] : slice_a_s;
      slice_b_s = (cnt_r == CW'(k)) ? b_r[k*CHUNK +: CHUNK] : slice_b_s;
    end
  end

  full_adder_chunk #(
    .CHUNK (CHUNK)
  ) u_fa (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (carry_r),
    .s    (slice_sum_s),
    .cout (slice_cout_s),
    .cmsb (slice_cmsb_s)
  );

  // State register; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (last_slice_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Operand capture, per-slice accumulation and final flag generation.
  // Subtraction is A + ~B + 1, so B is inverted on capture and the initial
  // carry forced to 1; the carry out then means "no borrow".
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      s_r     <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b ^ {WIDTH{sub}};
            carry_r <= sub ? 1'b1 : cin;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < N; k++) begin
            if (cnt_r == CW'(k)) begin
              s_r[k*CHUNK +: CHUNK] <= slice_sum_s;
            end
          end
          carry_r <= slice_cout_s;
          if (last_slice_s) begin
            cout_r <= slice_cout_s;
            ovf_r  <= slice_cmsb_s ^ slice_cout_s;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign s         = s_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed self-checking bench for chunked_adder. Two instances share the
// clock and reset: an 8-bit/2-bit-chunk adder (N=4) and an 8-bit/8-bit-chunk
// adder (N=1).
module tb_chunked_adder;

  logic       clk;
  logic       reset;

  logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [7:0] a, b, s;

  logic       w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready, w_cout, w_ovf;
  logic [7:0] w_a, w_b, w_s;

  int checks;
  int failures;

  chunked_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
  );

  chunked_adder #(.WIDTH(8), .CHUNK(8)) dut_w (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .s(w_s), .cout(w_cout), .ovf(w_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample and drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation to the N=4 instance and wait (bounded) for out_valid.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tc, input logic ts, output int lat);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'h5A; b = 8'hA5; cin = 1'b1; sub = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Accept the result with a one-cycle out_ready pulse.
  task automatic release_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 8'd0 || cout !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b s=%0d cout=%b ovf=%b exp rdy=1 vld=0 s=0 cout=0 ovf=0",
               in_ready, out_valid, s, cout, ovf);
    end
    checks++;
    if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0 || w_s !== 8'd0) begin
      failures++;
      $display("FAIL reset_state_n1 got rdy=%b vld=%b s=%0d exp rdy=1 vld=0 s=0", w_in_ready, w_out_valid, w_s);
    end
  endtask

  task automatic test_add();
    int lat;
    // 29 + 5: latency and basic sum
    start_op(8'd29, 8'd5, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL add_latency got=%0d exp=4", lat);
    end
    checks++;
    if (s !== 8'd34 || cout !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL add_29_5 got s=%0d cout=%b ovf=%b exp s=34 cout=0 ovf=0", s, cout, ovf);
    end
    release_op();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 8'd34) begin
      failures++;
      $display("FAIL release got rdy=%b vld=%b s=%0d exp rdy=1 vld=0 s=34", in_ready, out_valid, s);
    end
    // 200 + 95 wraps with carry out
    start_op(8'd200, 8'd95, 1'b0, 1'b0, lat);
    checks++;
    if (s !== 8'd39 || cout !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL add_200_95 got s=%0d cout=%b ovf=%b exp s=39 cout=1 ovf=0", s, cout, ovf);
    end
    release_op();
    // 78 + 255
    start_op(8'd78, 8'd255, 1'b0, 1'b0, lat);
    checks++;
    if (s !== 8'd77 || cout !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL add_78_255 got s=%0d cout=%b ovf=%b exp s=77 cout=1 ovf=0", s, cout, ovf);
    end
    release_op();
    // carry-in honoured in add mode: 10 + 20 + 1
    start_op(8'd10, 8'd20, 1'b1, 1'b0, lat);
    checks++;
    if (s !== 8'd31 || cout !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL add_cin got s=%0d cout=%b ovf=%b exp s=31 cout=0 ovf=0", s, cout, ovf);
    end
    release_op();
    // signed overflow: 100 + 100
    start_op(8'd100, 8'd100, 1'b0, 1'b0, lat);
    checks++;
    if (s !== 8'd200 || cout !== 1'b0 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL add_ovf got s=%0d cout=%b ovf=%b exp s=200 cout=0 ovf=1", s, cout, ovf);
    end
    release_op();
  endtask

  task automatic test_sub();
    int lat;
    // 43 - 59 borrows; cin must be ignored in sub mode
    start_op(8'd43, 8'd59, 1'b0, 1'b1, lat);
    checks++;
    if (s !== 8'd240 || cout !== 1'b0 || ovf !== 1'b0 || lat !== 4) begin
      failures++;
      $display("FAIL sub_43_59 got s=%0d cout=%b ovf=%b lat=%0d exp s=240 cout=0 ovf=0 lat=4", s, cout, ovf, lat);
    end
    release_op();
    start_op(8'd59, 8'd43, 1'b1, 1'b1, lat);
    checks++;
    if (s !== 8'd16 || cout !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL sub_59_43 got s=%0d cout=%b ovf=%b exp s=16 cout=1 ovf=0", s, cout, ovf);
    end
    release_op();
    // -128 - 1 overflows in two's complement
    start_op(8'h80, 8'h01, 1'b0, 1'b1, lat);
    checks++;
    if (s !== 8'h7F || cout !== 1'b1 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL sub_ovf got s=%0d cout=%b ovf=%b exp s=127 cout=1 ovf=1", s, cout, ovf);
    end
    release_op();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    start_op(8'd100, 8'd100, 1'b0, 1'b0, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = 8'hFF; b = 8'h01; sub = 1'b1;
      tick();
      if (s !== 8'd200 || cout !== 1'b0 || ovf !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL backpressure_hold got bad_cycles=%0d exp 0 (s=%0d cout=%b ovf=%b rdy=%b vld=%b)",
               bad, s, cout, ovf, in_ready, out_valid);
    end
    in_valid = 1'b0;
    release_op();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 8'd200 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release got rdy=%b vld=%b s=%0d ovf=%b exp rdy=1 vld=0 s=200 ovf=1",
               in_ready, out_valid, s, ovf);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    a = 8'd200; b = 8'd95; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 8'd0 || cout !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run got rdy=%b vld=%b s=%0d cout=%b exp rdy=1 vld=0 s=0 cout=0",
               in_ready, out_valid, s, cout);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_discard got out_valid_cycles=%0d exp 0", seen);
    end
    start_op(8'd17, 8'd28, 1'b0, 1'b0, lat);
    checks++;
    if (s !== 8'd45 || lat !== 4) begin
      failures++;
      $display("FAIL after_reset_add got s=%0d lat=%0d exp s=45 lat=4", s, lat);
    end
    // reset while holding a result in DONE
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== 8'd0) begin
      failures++;
      $display("FAIL reset_in_done got vld=%b rdy=%b s=%0d exp vld=0 rdy=1 s=0", out_valid, in_ready, s);
    end
  endtask

  task automatic test_single_chunk();
    int lat;
    w_a = 8'd191; w_b = 8'd2; w_cin = 1'b0; w_sub = 1'b0; w_in_valid = 1'b1;
    tick();
    w_in_valid = 1'b0;
    lat = 0;
    while (!w_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 1 || w_s !== 8'd193 || w_cout !== 1'b0 || w_ovf !== 1'b0) begin
      failures++;
      $display("FAIL n1_add got lat=%0d s=%0d cout=%b ovf=%b exp lat=1 s=193 cout=0 ovf=0",
               lat, w_s, w_cout, w_ovf);
    end
    w_out_ready = 1'b1;
    tick();
    w_out_ready = 1'b0;
    checks++;
    if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL n1_release got rdy=%b vld=%b exp rdy=1 vld=0", w_in_ready, w_out_valid);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    in_valid = 1'b0; a = 8'd0; b = 8'd0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_a = 8'd0; w_b = 8'd0; w_cin = 1'b0; w_sub = 1'b0; w_out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_single_chunk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset (one clock; reset synchronous, active-high).
REQ-005 SHALL have port in_valid, input, 1, operands present.
REQ-006 SHALL have port in_ready, output, 1, block can accept operands.
REQ-007 SHALL have port a, input, WIDTH, operand A.
REQ-008 SHALL have port b, input, WIDTH, operand B.
REQ-009 SHALL have port cin, input, 1, carry-in (add mode only).
REQ-010 SHALL have port sub, input, 1, mode: 0 = A+B+cin, 1 = A-B.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-013 SHALL have port s, output, WIDTH, result.
REQ-014 SHALL have port cout, output, 1, unsigned carry-out (sub: 1 = no borrow).
REQ-015 SHALL have port ovf, output, 1, two's-complement signed overflow.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-017 SHALL, on edge with IDLE and in_valid, latch a, b^{WIDTH{sub}}, initial carry = sub ? 1 : cin, clear chunk counter, enter RUN.
REQ-018 SHALL, in RUN, add one CHUNK slice per cycle, LSB slice first, carry registered between slices; slice k written into s[k*CHUNK +: CHUNK].
REQ-019 SHALL enter DONE on the edge that processes slice N-1; out_valid is high exactly N cycles after the accepting edge.
REQ-020 SHALL set cout = carry out of bit WIDTH-1 and ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, both valid with out_valid.
REQ-021 SHALL hold s, cout, ovf stable while DONE and out_ready low (back-pressure, unbounded).
REQ-022 SHALL return to IDLE on edge with DONE and out_ready; s/cout/ovf keep last values until next acceptance.
REQ-023 SHALL ignore in_valid, a, b, cin, sub outside IDLE; no overlapped transactions.
REQ-024 SHALL support N=1 (CHUNK==WIDTH): result in DONE one cycle after acceptance.
REQ-025 SHALL wrap the sum modulo 2^WIDTH.

Reset
REQ-026 SHALL, on clk edge with reset high, enter IDLE and clear s, cout, ovf, counter, carry to 0 regardless of state; reset has priority over all handshakes.
REQ-027 SHALL discard any in-flight operation on reset mid-RUN or mid-DONE; no out_valid is produced for it.
REQ-028 SHALL present in_ready=1, out_valid=0 in the first cycle after reset deasserts.

Structure
REQ-029 SHALL place state encoding (IDLE/RUN/DONE) and default WIDTH/CHUNK constants in a shared package adder_pkg.
REQ-030 SHALL instantiate one combinational sub-module full_adder_chunk (CHUNK-bit ripple adder: a, b, cin -> s, cout, carry into MSB) reused per cycle.
REQ-031 SHALL size the counter $clog2(N) bits, minimum 1.

Verification (WIDTH=8, CHUNK=2, N=4 unless stated)
REQ-032 SHALL check add 29+5, cin=0 -> s=34, cout=0, ovf=0, out_valid exactly 4 cycles after accept.
REQ-033 SHALL check add 200+95 -> s=39, cout=1; 78+255 -> s=77, cout=1, ovf=0.
REQ-034 SHALL check sub 43-59 -> s=240, cout=0, ovf=0; signed add 100+100 -> s=200, ovf=1, cout=0.
REQ-035 SHALL check out_ready held low 10 cycles after DONE -> s/cout/ovf stable, in_ready=0 throughout, new in_valid ignored.
REQ-036 SHALL check reset asserted at RUN slice 2 -> next cycle in_ready=1, out_valid=0, s=0; following 17+28 -> s=45.
REQ-037 SHALL check WIDTH=8, CHUNK=8 (N=1): 191+2 -> s=193, out_valid one cycle after accept.
